// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run controller and its host memory port.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        STEP
    } run_state_t;

    localparam logic HOST_SEL_IMEM = 1'b0;
    localparam logic HOST_SEL_DMEM = 1'b1;

    localparam int DRAIN_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/host_mem_port.sv
// Host access path to the core's instruction and data memories: request decode,
// read-pending tracking and registered read return with a one-cycle rvalid pulse.
import cpu_ctrl_pkg::*;

module host_mem_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        access_ok,
    input  logic        host_valid,
    input  logic        host_sel,
    input  logic        host_wr,
    input  logic [63:0] host_addr,
    input  logic [63:0] host_wdata,
    output logic        host_ready,
    output logic [63:0] host_rdata,
    output logic        host_rvalid,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2
);

    logic rd_pending;
    logic rd_sel;
    logic accept;
    logic imem_hit;
    logic dmem_hit;

    // Unselected port is held at all-zero so it never looks like a request.
    always_comb begin
        host_ready  = access_ok && !rd_pending;
        accept      = host_valid && host_ready;
        imem_hit    = accept && (host_sel == HOST_SEL_IMEM);
        dmem_hit    = accept && (host_sel == HOST_SEL_DMEM);
        addr_ext    = imem_hit ? host_addr : '0;
        wen_ext     = imem_hit && host_wr;
        ren_ext     = imem_hit && !host_wr;
        wdata_ext   = imem_hit ? host_wdata[31:0] : '0;
        addr_ext_2  = dmem_hit ? host_addr : '0;
        wen_ext_2   = dmem_hit && host_wr;
        ren_ext_2   = dmem_hit && !host_wr;
        wdata_ext_2 = dmem_hit ? host_wdata : '0;
    end

    // SRAM data is valid the cycle after ren; capture it then and pulse rvalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending  <= 1'b0;
            rd_sel      <= HOST_SEL_IMEM;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            rd_pending  <= accept && !host_wr;
            host_rvalid <= rd_pending;
            if (accept)
                rd_sel <= host_sel;
            if (rd_pending)
                host_rdata <= (rd_sel == HOST_SEL_DMEM) ? rdata_ext_2 : {32'b0, rdata_ext};
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller sequencing the core through load, run, drain and readback.
// Optional single-step mode is enabled with the CPU_RUN_CTRL_STEP_EN macro.
import cpu_ctrl_pkg::*;

module cpu_run_ctrl #(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef CPU_RUN_CTRL_STEP_EN
    input  logic             step,
`endif
    input  logic             halt_req,
    input  logic [CNT_W-1:0] cycle_limit,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic             host_sel,
    input  logic             host_wr,
    input  logic [63:0]      host_addr,
    input  logic [63:0]      host_wdata,
    output logic [63:0]      host_rdata,
    output logic             host_rvalid,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    run_state_t       state;
    logic [DW-1:0]    drain_cnt;
    logic             access_ok;
    logic             start_ok;
    logic [CNT_W-1:0] count_plus;
    logic [CNT_W-1:0] count_sat;

    // start only wins when the host is neither requesting nor awaiting read data.
    always_comb begin
        access_ok  = (state == IDLE) || (state == DONE);
        start_ok   = start && host_ready && !host_valid;
        count_plus = cycle_count + 1'b1;
        count_sat  = (&cycle_count) ? cycle_count : count_plus;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cpu_enable  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            drain_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state       <= RUN;
                        cpu_enable  <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                    end
`ifdef CPU_RUN_CTRL_STEP_EN
                    else if (step && host_ready && !host_valid) begin
                        state      <= STEP;
                        cpu_enable <= 1'b1;
                        done       <= 1'b0;
                    end
`endif
                end
                RUN: begin
                    cycle_count <= count_sat;
                    if (halt_req) begin
                        state     <= DRAIN;
                        timeout   <= 1'b0;
                        drain_cnt <= DRAIN_LOAD;
                    end else if ((cycle_limit != '0) && (count_plus == cycle_limit)) begin
                        state     <= DRAIN;
                        timeout   <= 1'b1;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state      <= DONE;
                        cpu_enable <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
`ifdef CPU_RUN_CTRL_STEP_EN
                STEP: begin
                    cycle_count <= count_sat;
                    state       <= DONE;
                    cpu_enable  <= 1'b0;
                    done        <= 1'b1;
                end
`endif
                default: begin
                    state      <= IDLE;
                    cpu_enable <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    host_mem_port u_host_mem_port (
        .clk         (clk),
        .rst         (rst),
        .access_ok   (access_ok),
        .host_valid  (host_valid),
        .host_sel    (host_sel),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ready  (host_ready),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl with simple imem/dmem SRAM models.
// Step-mode checks are included when CPU_RUN_CTRL_STEP_EN is defined.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        step;
    logic        halt_req;
    logic [31:0] cycle_limit;
    logic        host_valid;
    logic        host_ready;
    logic        host_sel;
    logic        host_wr;
    logic [63:0] host_addr;
    logic [63:0] host_wdata;
    logic [63:0] host_rdata;
    logic        host_rvalid;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [31:0] rdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cycles = 0;
    int port_viol = 0;
    int en_mark;

    logic [31:0] imem [0:15];
    logic [63:0] dmem [0:15];

    always #5 clk = ~clk;

    cpu_run_ctrl #(.DRAIN_CYCLES(4), .CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef CPU_RUN_CTRL_STEP_EN
        .step        (step),
`endif
        .halt_req    (halt_req),
        .cycle_limit (cycle_limit),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_sel    (host_sel),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rdata  (host_rdata),
        .host_rvalid (host_rvalid),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .rdata_ext   (rdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    // Synchronous SRAMs: data appears the cycle after ren.
    always @(posedge clk) begin
        if (wen_ext)   imem[addr_ext[5:2]]   <= wdata_ext;
        if (ren_ext)   rdata_ext             <= imem[addr_ext[5:2]];
        if (wen_ext_2) dmem[addr_ext_2[6:3]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2           <= dmem[addr_ext_2[6:3]];
    end

    // Enable-cycle tally and guard against memory traffic while the core runs.
    always @(negedge clk) begin
        if (cpu_enable) en_cycles++;
        if (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) port_viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic w,
                                 input logic [63:0] a, input logic [63:0] d);
        host_valid = v;
        host_sel   = s;
        host_wr    = w;
        host_addr  = a;
        host_wdata = d;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0; cycle_limit = 32'd0;
        rdata_ext = '0; rdata_ext_2 = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        tick();
        checkOutput("reset_cpu_enable", cpu_enable, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_timeout", timeout, 0);
        checkOutput("reset_cycle_count", cycle_count, 0);
        checkOutput("reset_rvalid", host_rvalid, 0);
        checkOutput("reset_rdata", host_rdata, 0);
        checkOutput("reset_wen_ext", wen_ext, 0);
        rst = 1'b0;
        tick();
        $display("[TB] reset released");

        // imem write with junk in the upper data half
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h8, 64'hDEADBEEF_00A00093);
        checkOutput("imem_wr_ready", host_ready, 1);
        checkOutput("imem_wr_wen", wen_ext, 1);
        checkOutput("imem_wr_addr", addr_ext, 64'h8);
        checkOutput("imem_wr_wdata", wdata_ext, 64'h00A00093);
        checkOutput("imem_wr_dmem_idle", {wen_ext_2, ren_ext_2, addr_ext_2[3:0]}, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("imem_wr_wen_drop", wen_ext, 0);

        // imem read back
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h8, 64'h0);
        checkOutput("imem_rd_ren", ren_ext, 1);
        checkOutput("imem_rd_wen", wen_ext, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("imem_rd_pending_ready", host_ready, 0);
        checkOutput("imem_rd_early_rvalid", host_rvalid, 0);
        tick();
        checkOutput("imem_rd_rvalid", host_rvalid, 1);
        checkOutput("imem_rd_rdata", host_rdata, 64'h00000000_00A00093);
        checkOutput("imem_rd_ready_back", host_ready, 1);
        tick();
        checkOutput("imem_rd_rvalid_pulse", host_rvalid, 0);

        // dmem write and read back
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h10, 64'h11223344_55667788);
        checkOutput("dmem_wr_wen", wen_ext_2, 1);
        checkOutput("dmem_wr_wdata", wdata_ext_2, 64'h11223344_55667788);
        checkOutput("dmem_wr_imem_idle", {wen_ext, ren_ext}, 0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h10, 64'h0);
        checkOutput("dmem_rd_ren", ren_ext_2, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        checkOutput("dmem_rd_rvalid", host_rvalid, 1);
        checkOutput("dmem_rd_rdata", host_rdata, 64'h11223344_55667788);

        // start together with a host access: the access wins
        start = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h18, 64'hCAFE);
        checkOutput("start_host_wen", wen_ext_2, 1);
        tick();
        start = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        checkOutput("start_host_busy", busy, 0);
        checkOutput("start_host_enable", cpu_enable, 0);

        // run halted on the 10th RUN cycle
        cycle_limit = 32'd0;
        en_mark = en_cycles;
        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h20, 64'h1234);
        checkOutput("run_host_ready", host_ready, 0);
        checkOutput("run_host_ports", {wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 0);
        checkOutput("run_enable", cpu_enable, 1);
        checkOutput("run_busy", busy, 1);
        checkOutput("run_count_first", cycle_count, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        repeat (8) tick();
        checkOutput("run_count_c10", cycle_count, 9);
        halt_req = 1'b1;
        tick();
        checkOutput("drain_count", cycle_count, 10);
        checkOutput("drain_busy", busy, 1);
        checkOutput("drain_timeout", timeout, 0);
        repeat (3) tick();
        checkOutput("drain_last_enable", cpu_enable, 1);
        tick();
        halt_req = 1'b0;
        checkOutput("halt_done", done, 1);
        checkOutput("halt_enable", cpu_enable, 0);
        checkOutput("halt_busy", busy, 0);
        checkOutput("halt_timeout", timeout, 0);
        checkOutput("halt_count", cycle_count, 10);
        checkOutput("halt_en_cycles", en_cycles - en_mark, 14);
        tick();
        tick();
        checkOutput("done_count_frozen", cycle_count, 10);

        // readback in DONE
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h10, 64'h0);
        checkOutput("done_host_ready", host_ready, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        checkOutput("done_rd_rdata", host_rdata, 64'h11223344_55667788);

        // run ended by cycle_limit
        cycle_limit = 32'd5;
        en_mark = en_cycles;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("lim_done_cleared", done, 0);
        checkOutput("lim_count_cleared", cycle_count, 0);
        repeat (4) tick();
        checkOutput("lim_count_c5", cycle_count, 4);
        checkOutput("lim_busy_c5", busy, 1);
        tick();
        checkOutput("lim_drain_count", cycle_count, 5);
        checkOutput("lim_drain_timeout", timeout, 1);
        repeat (3) tick();
        checkOutput("lim_drain_enable", cpu_enable, 1);
        tick();
        checkOutput("lim_done", done, 1);
        checkOutput("lim_timeout", timeout, 1);
        checkOutput("lim_count", cycle_count, 5);
        checkOutput("lim_en_cycles", en_cycles - en_mark, 9);

        // reset during DRAIN
        cycle_limit = 32'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tick();
        checkOutput("rstdrain_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstdrain_enable", cpu_enable, 0);
        checkOutput("rstdrain_done", done, 0);
        checkOutput("rstdrain_count", cycle_count, 0);
        checkOutput("rstdrain_busy", busy, 0);
        checkOutput("rstdrain_ready", host_ready, 1);

        // reset drops a pending read
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h10, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rstrd_rvalid_a", host_rvalid, 0);
        tick();
        checkOutput("rstrd_rvalid_b", host_rvalid, 0);
        checkOutput("rstrd_rdata", host_rdata, 0);

`ifdef CPU_RUN_CTRL_STEP_EN
        en_mark = en_cycles;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            checkOutput("step_enable", cpu_enable, 1);
            tick();
            checkOutput("step_enable_drop", cpu_enable, 0);
            checkOutput("step_done", done, 1);
            checkOutput("step_count", cycle_count, 64'(i + 1));
        end
        checkOutput("step_en_cycles", en_cycles - en_mark, 3);
`endif

        checkOutput("no_port_while_enabled", port_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run controller that sequences the pipelined 64-bit RISC-V core through its lifecycle: program load, execution, pipeline drain and result readback.
- Owns the core's enable input and both external memory ports (instruction memory: 32-bit data; data memory: 64-bit data).
- Arbitrates host access to the memories against CPU execution.
- Sits between the host/testbench interface and the cpu top.

Parameters:
DRAIN_CYCLES, 4, cycles cpu_enable stays high after a halt so in-flight instructions (IF..WB) retire
CNT_W, 32, width of cycle counter and cycle_limit

Ports:
clk  in  1  system clock (one clock; reset is synchronous and active-high)
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin execution
halt_req  in  1  level: program reached halt point (from integration logic)
cycle_limit  in  CNT_W  max RUN cycles; 0 = unlimited
host_valid  in  1  host memory request valid
host_ready  out  1  controller accepts request this cycle
host_sel  in  1  0 = instruction memory, 1 = data memory
host_wr  in  1  1 = write, 0 = read
host_addr  in  64  byte address, passed through unchanged
host_wdata  in  64  write data; imem uses [31:0]
host_rdata  out  64  read data; imem reads zero-extended
host_rvalid  out  1  one-cycle pulse, host_rdata valid
cpu_enable  out  1  to core enable
addr_ext, wen_ext, ren_ext, wdata_ext[31:0]  out  -  imem external port
rdata_ext  in  32  imem external read data
addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2[63:0]  out  -  dmem external port
rdata_ext_2  in  64  dmem external read data
busy  out  1  state is RUN or DRAIN
done  out  1  state is DONE
timeout  out  1  last run ended on cycle_limit
cycle_count  out  CNT_W  RUN cycles of the current or last run

Behaviour:
- Reset values: state IDLE. All outputs 0; wen/ren/addr/wdata outputs 0; cycle_count 0.
- States: IDLE, RUN, DRAIN, DONE.
- host_ready = 1 only in IDLE or DONE with no read return pending.
- Host write: on accept, the selected wen_ext* is high for exactly that cycle, combinationally with addr/wdata. Unselected port stays idle.
- Host read: on accept, the selected ren_ext* is high that cycle. SRAM data returns next cycle. host_rdata is registered from that data, and host_rvalid pulses the following cycle. Total read latency is 2 cycles from accept. host_ready is 0 during the pending cycle.
- IDLE/DONE -> RUN on start.
  - start is ignored if host_valid=1 in the same cycle; the host access wins.
  - start is ignored while a read is pending, and in RUN and DRAIN.
  - Entry into RUN clears cycle_count, done and timeout.
- RUN: cpu_enable=1; cycle_count increments every cycle and saturates at all-ones.
  - If halt_req -> DRAIN, timeout=0.
  - Else if cycle_limit!=0 and cycle_count+1==cycle_limit -> DRAIN, timeout=1.
  - halt_req takes priority when both occur in the same cycle.
- DRAIN: cpu_enable=1 for exactly DRAIN_CYCLES cycles (internal down-counter); halt_req is ignored. Then -> DONE. Programs must place >= DRAIN_CYCLES NOPs after the halt point.
- DONE: cpu_enable=0, done=1, cycle_count frozen; host accesses are allowed for readback.
- cpu_enable is registered, deasserted the cycle after the DRAIN counter expires. External ports must never be driven while cpu_enable=1.
- rst mid-run: next edge returns to IDLE. A pending read is dropped with no rvalid. cpu_enable drops in the same cycle as the reset edge.

Optional Feature:
CPU_RUN_CTRL_STEP_EN: adds input step.
- With the macro: in IDLE or DONE with no host activity, a step pulse enters STEP. STEP holds cpu_enable=1 for one cycle, increments cycle_count, then returns to DONE with done=1. start has priority over step.
- Without the macro: no step port, no STEP state.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE, STEP)
  - HOST_SEL_IMEM=0, HOST_SEL_DMEM=1
  - DRAIN_CYCLES_DEFAULT=4
- One natural sub-module: host_mem_port. It handles the request decode to the imem/dmem ext ports, the read-pending flag, and the rdata capture/zero-extend with rvalid. The FSM, counters and enable live in cpu_run_ctrl.

Test Plan:
- Write imem addr 0x8 data 0x00A00093 (sel=0, wr=1), then read it back -> wen_ext high 1 cycle with wdata_ext=0x00A00093; read returns host_rdata=0x00000000_00A00093, rvalid 2 cycles after accept.
- start, halt_req asserted on the 10th RUN cycle, DRAIN_CYCLES=4 -> cycle_count=10, cpu_enable high exactly 14 cycles, done=1, timeout=0.
- cycle_limit=5, halt_req never asserted -> cycle_count=5, timeout=1, done after 4 drain cycles.
- host_valid during RUN -> host_ready=0, no wen/ren pulses; same cycle start+host_valid in IDLE -> access performed, state stays IDLE.
- rst asserted in DRAIN -> next cycle IDLE, cpu_enable=0, done=0, cycle_count=0.
- (STEP_EN) three step pulses from DONE -> cycle_count=3, cpu_enable high exactly 3 non-consecutive cycles, done=1 after each.
